seq_bit_serializer: RTL and testbench

Upstream stage of the serial sequence detectors. Accepts parallel words over a valid/ready handshake and shifts them out one bit per enabled cycle onto a single-bit serial line, which drives the detector's serial input directly. A one-word holding buffer allows back-to-back words with no bubble, so the detectors see uninterrupted bit streams, including patterns that span word boundaries.

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/seq_shift_reg.sv | 23 ++
 rtl/seq_bit_serializer.sv | 125 ++++++++++++
 tb/tb_seq_bit_serializer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serializer and the serial sequence detectors.
package seq_det_pkg;
  typedef enum logic [1:0] {
    SER_IDLE  = 2'b00,
    SER_SHIFT = 2'b01,
    SER_GAP   = 2'b10
  } ser_state_e;

  localparam int          SER_DEF_WIDTH = 8;
  localparam logic [4:0]  SEQ_PAT_10010 = 5'b10010;
endpackage

// File: rtl/seq_shift_reg.sv
// Load/shift register; head bit is the next bit to leave in the chosen direction.
module seq_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_head
);
  logic [WIDTH-1:0] r_sh;

  // Load wins over shift so a reload on the last bit starts the next word cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_sh <= '0;
    else if (i_load)  r_sh <= i_d;
    else if (i_shift) r_sh <= MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
  end

  assign o_head = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end with a one-word holding buffer and optional inter-word gap.
module seq_bit_serializer
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = SER_DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  ser_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hold_data;
  logic             r_hold_full;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [3:0]       r_gcnt, w_gcnt_nxt;
  logic             r_word_done;
  logic             w_load, w_shift, w_done, w_accept, w_head;

  assign w_accept = s_valid && !r_hold_full;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gcnt_nxt  = r_gcnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_cnt_nxt   = CW'(WIDTH);
          w_state_nxt = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (bit_en) begin
          w_shift   = 1'b1;
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_done = 1'b1;
            if (GAP > 0) begin
              w_gcnt_nxt  = 4'(GAP);
              w_state_nxt = SER_GAP;
            end else if (r_hold_full) begin
              w_load    = 1'b1;
              w_cnt_nxt = CW'(WIDTH);
            end else begin
              w_state_nxt = SER_IDLE;
            end
          end
        end
      end
      SER_GAP: begin
        if (bit_en) begin
          w_gcnt_nxt = r_gcnt - 4'd1;
          if (r_gcnt == 4'd1) begin
            if (r_hold_full) begin
              w_load      = 1'b1;
              w_cnt_nxt   = CW'(WIDTH);
              w_state_nxt = SER_SHIFT;
            end else begin
              w_state_nxt = SER_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SER_IDLE;
      r_cnt       <= '0;
      r_gcnt      <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gcnt      <= w_gcnt_nxt;
      r_word_done <= w_done;
    end
  end

  // The buffer only accepts when empty, so accept and drain never collide on the same word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= s_data;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  seq_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sh (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_d     (r_hold_data),
    .o_head  (w_head)
  );

  assign s_ready   = !r_hold_full;
  assign ser_valid = (r_state == SER_SHIFT);
  assign ser_out   = ser_valid ? w_head : IDLE_BIT;
  assign word_done = r_word_done;
  assign busy      = (r_state != SER_IDLE) || r_hold_full;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench: two serializer configs share clock, reset and bit_en.
module tb_seq_bit_serializer;
  localparam int W   = 8;
  localparam int G1  = 2;
  localparam bit IB1 = 1'b1;

  typedef struct packed {logic b; logic last;} ebit_t;

  logic clk = 1'b0, rst, bit_en;
  logic [W-1:0] sd0, sd1;
  logic sv0, sv1, sr0, sr1, so0, so1, svl0, svl1, wd0, wd1, bz0, bz1;
  int checks = 0, errors = 0, bmode = 0;

  ebit_t q0[$], q1[$];
  logic exp_done[2], in_gap[2], strict[2];
  int   gap_slots[2];

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .s_data(sd0), .s_valid(sv0), .s_ready(sr0), .bit_en(bit_en),
    .ser_out(so0), .ser_valid(svl0), .word_done(wd0), .busy(bz0));

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IB1), .GAP(G1)) dut1 (
    .clk(clk), .rst(rst), .s_data(sd1), .s_valid(sv1), .s_ready(sr1), .bit_en(bit_en),
    .ser_out(so1), .ser_valid(svl1), .word_done(wd1), .busy(bz1));

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int d);  return d == 0 ? 0 : G1; endfunction
  function automatic logic idle_of(input int d); return d == 0 ? 1'b0 : IB1; endfunction
  function automatic int qsz(input int d);     return d == 0 ? q0.size() : q1.size(); endfunction
  function automatic logic rdy(input int d);   return d == 0 ? sr0 : sr1; endfunction
  function automatic logic svl(input int d);   return d == 0 ? svl0 : svl1; endfunction

  // Reference model: an accepted word becomes WIDTH bits in send order.
  function automatic void push_word(input int d, input logic [W-1:0] w);
    ebit_t e;
    for (int i = 0; i < W; i++) begin
      e.b    = (d == 0) ? w[W-1-i] : w[i];
      e.last = (i == W-1);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endfunction

  // bit_en source: 0 = always on, 1 = toggle, 2 = random, 3 = driven by the main sequence.
  initial begin
    bit_en = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bmode)
        0: bit_en = 1'b1;
        1: bit_en = ~bit_en;
        2: bit_en = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic so, sv, wd, vin, rd;
    logic [W-1:0] sd;
    ebit_t e;
    if (rst) begin
      q0.delete(); q1.delete();
      for (int d = 0; d < 2; d++) begin
        exp_done[d] = 0; in_gap[d] = 0; strict[d] = 0; gap_slots[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        so  = d == 0 ? so0  : so1;
        sv  = d == 0 ? svl0 : svl1;
        wd  = d == 0 ? wd0  : wd1;
        vin = d == 0 ? sv0  : sv1;
        rd  = d == 0 ? sr0  : sr1;
        sd  = d == 0 ? sd0  : sd1;
        chk($sformatf("word_done%0d", d), wd, exp_done[d]);
        exp_done[d] = 0;
        if (sv) begin
          if (in_gap[d]) begin
            if (strict[d]) chk($sformatf("gap_len%0d", d), gap_slots[d], gap_of(d));
            else           chk($sformatf("gap_min%0d", d), gap_slots[d] >= gap_of(d), 1);
            in_gap[d] = 0;
          end
          if (qsz(d) == 0) begin
            checks++; errors++;
            $display("FAIL stray_bit%0d actual=ser_valid expected=idle t=%0t", d, $time);
          end else begin
            e = d == 0 ? q0[0] : q1[0];
            chk($sformatf("ser_out%0d", d), so, e.b);
            if (bit_en) begin
              if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
              if (e.last) begin
                exp_done[d] = 1; in_gap[d] = 1; gap_slots[d] = 0;
                strict[d] = (qsz(d) != 0);
              end
            end
          end
        end else begin
          chk($sformatf("idle_level%0d", d), so, idle_of(d));
          if (in_gap[d] && bit_en) gap_slots[d]++;
        end
        if (vin && rd) push_word(d, sd);
      end
    end
  end

  task automatic send_word(input int d, input logic [W-1:0] w);
    int n = 0;
    if (d == 0) begin sd0 = w; sv0 = 1'b1; end else begin sd1 = w; sv1 = 1'b1; end
    @(negedge clk);
    while (!rdy(d)) begin
      if (++n > 200) begin chk("send_timeout", n, 0); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    if (d == 0) sv0 = 1'b0; else sv1 = 1'b0;
  endtask

  task automatic measure_runs(input int d, output int r1, output int g, output int r2);
    int n = 0;
    r1 = 0; g = 0; r2 = 0;
    while (!svl(d) && n < 100) begin @(posedge clk); #1; n++; end
    while (svl(d) && r1 < 100) begin r1++; @(posedge clk); #1; end
    while (!svl(d) && g < 30)  begin g++;  @(posedge clk); #1; end
    while (svl(d) && r2 < 100) begin r2++; @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || bz0 || bz1) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_in_time", n < 1000, 1);
  endtask

  initial begin
    int r1, g, r2, cnt, bad;
    rst = 1'b1; sv0 = 0; sv1 = 0; sd0 = '0; sd1 = '0;
    #1;
    chk("rst_ser_out0", so0, 0);  chk("rst_ser_valid0", svl0, 0);
    chk("rst_word_done0", wd0, 0); chk("rst_s_ready0", sr0, 1);
    chk("rst_busy0", bz0, 0);     chk("rst_ser_out1", so1, IB1);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("idle_busy0", bz0, 0); chk("idle_s_ready0", sr0, 1);

    // Single word: first bit two cycles after accept.
    send_word(0, 8'b1001_0000);
    chk("lat_t1_valid", svl0, 0); chk("lat_t1_busy", bz0, 1); chk("lat_t1_ready", sr0, 0);
    @(posedge clk); #1;
    chk("lat_t2_valid", svl0, 1); chk("lat_t2_bit", so0, 1);
    drain();

    // Back-to-back words, no bubble.
    fork
      begin send_word(0, 8'hA5); send_word(0, 8'h3C); end
      measure_runs(0, r1, g, r2);
    join
    chk("b2b_run", r1, 16);
    drain();

    // Stall: each bit held two cycles.
    bmode = 3;
    send_word(0, 8'hF0);
    bit_en = 1'b0;
    @(posedge clk); #1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      bit_en = i[0];
      if (svl0) cnt++;
      @(posedge clk); #1;
    end
    chk("stall_valid_cycles", cnt, 16);
    chk("stall_word_done", wd0, 1);
    chk("stall_after_valid", svl0, 0);
    bmode = 0;
    drain();

    // LSB-first with a two-slot gap between words.
    fork
      begin send_word(1, 8'h01); send_word(1, 8'h80); end
      measure_runs(1, r1, g, r2);
    join
    chk("gap_run1", r1, 8); chk("gap_slots", g, G1); chk("gap_run2", r2, 8);
    drain();

    // Reset mid-word with a second word held.
    send_word(0, 8'hFF);
    send_word(0, 8'h55);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ser_out", so0, 0); chk("mid_rst_valid", svl0, 0);
    chk("mid_rst_done", wd0, 0);    chk("mid_rst_busy", bz0, 0);
    chk("mid_rst_ready", sr0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    repeat (20) begin @(posedge clk); #1; if (svl0 || wd0 || bz0) bad++; end
    chk("post_rst_quiet", bad, 0);

    // Randomized traffic on both configs with random bit_en.
    bmode = 2;
    fork
      repeat (50) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send_word(0, W'($urandom));
      end
      repeat (50) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send_word(1, W'($urandom));
      end
    join
    bmode = 0;
    drain();
    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
